// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: arbiter state encoding, byte width and default sizing.
// The transmit generators import this package too.
package bus_pkg;

   localparam int BYTE_W      = 8;
   localparam int N_REQ_DEF   = 3;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      WAIT_FIN = 2'd2
   } bus_state_t;

   // Index of the set bit in a one-hot vector of up to 8 bits (0 when empty).
   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo N. Output is one-hot, or zero when no request is set.
module rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     onehot
);

   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      onehot = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            onehot[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the single serial-bus transmitter.
// The owner keeps the bus until its last byte finishes, aborts, or the watchdog fires.
module bus_tx_arbiter
   import bus_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = 10,
   localparam int PTR_W  = $clog2(N_REQ)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [BYTE_W*N_REQ-1:0] req_byte,
   input  logic [N_REQ-1:0]        req_byte_flag,
   input  logic [N_REQ-1:0]        req_byte_last,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        req_send_finish,
   output logic [BYTE_W-1:0]       bus_data,
   output logic                    bus_data_flag,
   input  logic                    bus_send_finish,
   output logic                    busy,
   output logic                    timeout_err,
   output logic                    proto_err,
   output bus_state_t              state,
   output logic [PTR_W-1:0]        rr_ptr
);

   bus_state_t        state_d;
   logic [PTR_W-1:0]  owner_q, owner_d, rr_ptr_d, owner_next;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [N_REQ-1:0]  grant_d, fin_d, pick_oh;
   logic [BYTE_W-1:0] bus_data_d, own_byte;
   logic              flag_d, to_d, pe_d, busy_d;
   logic              own_valid, own_flag, own_last;

   rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_oh)
   );

   assign own_valid  = req_valid[owner_q];
   assign own_flag   = req_byte_flag[owner_q];
   assign own_last   = req_byte_last[owner_q];
   assign own_byte   = req_byte[int'(owner_q)*BYTE_W +: BYTE_W];
   assign owner_next = (owner_q == PTR_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;

   // Valid/ready: a requester strobe is accepted only by the owner in GRANT; the
   // transmitter's bus_send_finish is the ready for each forwarded byte.
   always_comb begin
      state_d    = state;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr;
      cnt_d      = cnt_q;
      last_d     = last_q;
      grant_d    = grant;
      bus_data_d = bus_data;
      flag_d     = 1'b0;
      fin_d      = '0;
      to_d       = 1'b0;
      pe_d       = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               owner_d = PTR_W'(onehot_idx(8'(pick_oh)));
               grant_d = pick_oh;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (own_flag) begin
               bus_data_d = own_byte;
               flag_d     = 1'b1;
               last_d     = own_last;
               state_d    = WAIT_FIN;
            end else if (!own_valid || cnt_q == TO_W'(TIMEOUT-1)) begin
               to_d     = own_valid;
               grant_d  = '0;
               rr_ptr_d = owner_next;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_FIN: begin
            pe_d = own_flag;
            if (bus_send_finish) begin
               fin_d[owner_q] = 1'b1;
               if (last_q) begin
                  grant_d  = '0;
                  rr_ptr_d = owner_next;
                  state_d  = IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = GRANT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state           <= IDLE;
         owner_q         <= '0;
         rr_ptr          <= '0;
         cnt_q           <= '0;
         last_q          <= 1'b0;
         grant           <= '0;
         req_send_finish <= '0;
         bus_data        <= '0;
         bus_data_flag   <= 1'b0;
         busy            <= 1'b0;
         timeout_err     <= 1'b0;
         proto_err       <= 1'b0;
      end else begin
         state           <= state_d;
         owner_q         <= owner_d;
         rr_ptr          <= rr_ptr_d;
         cnt_q           <= cnt_d;
         last_q          <= last_d;
         grant           <= grant_d;
         req_send_finish <= fin_d;
         bus_data        <= bus_data_d;
         bus_data_flag   <= flag_d;
         busy            <= busy_d;
         timeout_err     <= to_d;
         proto_err       <= pe_d;
      end
   end

endmodule

// File: tb/tb_bus_tx_arbiter.sv
// Directed bench for bus_tx_arbiter (N_REQ=3, TIMEOUT=16): single frame, contention,
// interlopers, watchdog, overlap violation and mid-frame reset.
module tb_bus_tx_arbiter;
   import bus_pkg::*;

   localparam int N = 3;

   logic           sys_clk = 1'b0;
   logic           sys_rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_byte = '0;
   logic [N-1:0]   req_byte_flag = '0;
   logic [N-1:0]   req_byte_last = '0;
   logic [N-1:0]   grant, req_send_finish;
   logic [7:0]     bus_data;
   logic           bus_data_flag, bus_send_finish = 1'b0;
   logic           busy, timeout_err, proto_err;
   bus_state_t     state;
   logic [1:0]     rr_ptr;

   int total = 0;
   int bad = 0;
   int pe_cnt = 0;
   logic [7:0] exp_q[$];

   bus_tx_arbiter #(.N_REQ(N), .TIMEOUT(16), .TO_W(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_byte(req_byte),
      .req_byte_flag(req_byte_flag), .req_byte_last(req_byte_last), .grant(grant),
      .req_send_finish(req_send_finish), .bus_data(bus_data), .bus_data_flag(bus_data_flag),
      .bus_send_finish(bus_send_finish), .busy(busy), .timeout_err(timeout_err),
      .proto_err(proto_err), .state(state), .rr_ptr(rr_ptr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Scoreboard for forwarded bytes, grant one-hotness and proto_err pulses.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
         if (bus_data_flag) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(bus_data), 32'hFFFF);
            else chk("byte", 32'(bus_data), 32'(exp_q.pop_front()));
         end
         if (proto_err) pe_cnt++;
      end
   end

   task automatic do_reset();
      sys_rst = 1'b1;
      req_valid = '0; req_byte_flag = '0; req_byte_last = '0; bus_send_finish = 1'b0;
      step(); step();
      sys_rst = 1'b0;
      exp_q.delete();
      pe_cnt = 0;
   endtask

   // Owner r strobes byte b, transmitter finishes lat cycles after the strobe edge.
   task automatic send_byte(input int r, input logic [7:0] b, input logic last, input int lat);
      req_byte[8*r +: 8] = b;
      req_byte_flag[r] = 1'b1;
      req_byte_last[r] = last;
      exp_q.push_back(b);
      step();
      req_byte_flag = '0;
      req_byte_last = '0;
      repeat (lat - 1) step();
      bus_send_finish = 1'b1;
      step();
      bus_send_finish = 1'b0;
   endtask

   initial begin
      int order[4];
      int waited;
      order = '{0, 1, 2, 0};

      // Reset values
      step();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_fin", 32'(req_send_finish), 0);
      chk("rst_data", 32'(bus_data), 0);
      chk("rst_flag", 32'(bus_data_flag), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_to", 32'(timeout_err), 0);
      chk("rst_pe", 32'(proto_err), 0);
      chk("rst_state", 32'(state), 32'(IDLE));
      chk("rst_ptr", 32'(rr_ptr), 0);
      do_reset();

      // Single frame from requester 1
      req_valid = 3'b010;
      step();
      chk("sf_grant", 32'(grant), 32'b010);
      chk("sf_busy", 32'(busy), 1);
      chk("sf_state", 32'(state), 32'(GRANT));
      send_byte(1, 8'hA5, 1'b0, 5);
      chk("sf_fin1", 32'(req_send_finish), 32'b010);
      chk("sf_state2", 32'(state), 32'(GRANT));
      chk("sf_grant2", 32'(grant), 32'b010);
      step();
      chk("sf_fin1_width", 32'(req_send_finish), 0);
      send_byte(1, 8'h3C, 1'b1, 5);
      req_valid = '0;
      chk("sf_fin2", 32'(req_send_finish), 32'b010);
      chk("sf_release", 32'(grant), 0);
      chk("sf_ptr", 32'(rr_ptr), 2);
      chk("sf_idle", 32'(busy), 0);
      step();
      chk("sf_no_regrant", 32'(grant), 0);

      // Contention: all requesters valid from reset
      sys_rst = 1'b1;
      step();
      req_valid = 3'b111;
      sys_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         while (grant == '0 && waited < 20) begin
            step();
            waited++;
         end
         chk("ct_wait", 32'(waited), 1);
         chk("ct_grant", 32'(grant), 32'(1 << order[k]));
         send_byte(order[k], 8'(8'h50 + k), 1'b1, 2);
         if (k == 3) req_valid = '0;
         chk("ct_release", 32'(grant), 0);
      end
      step();

      // Mid-frame interloper on requester 2
      do_reset();
      req_valid = 3'b001;
      step();
      chk("ip_grant", 32'(grant), 32'b001);
      req_byte = {8'h77, 8'h00, 8'h11};
      req_byte_flag = 3'b101;
      exp_q.push_back(8'h11);
      step();
      req_byte_flag = 3'b100;
      chk("ip_state", 32'(state), 32'(WAIT_FIN));
      step();
      req_byte_flag = '0;
      step();
      bus_send_finish = 1'b1;
      step();
      bus_send_finish = 1'b0;
      chk("ip_fin", 32'(req_send_finish), 32'b001);
      send_byte(0, 8'h22, 1'b1, 2);
      req_valid = '0;
      chk("ip_release", 32'(grant), 0);
      step();
      chk("ip_pe_cnt", 32'(pe_cnt), 0);

      // Watchdog
      do_reset();
      req_valid = 3'b011;
      step();
      chk("wd_grant", 32'(grant), 32'b001);
      repeat (15) step();
      chk("wd_early", 32'(timeout_err), 0);
      chk("wd_hold", 32'(grant), 32'b001);
      step();
      chk("wd_to", 32'(timeout_err), 1);
      chk("wd_release", 32'(grant), 0);
      chk("wd_ptr", 32'(rr_ptr), 1);
      step();
      chk("wd_next", 32'(grant), 32'b010);
      chk("wd_to_width", 32'(timeout_err), 0);
      req_valid = '0;
      step();
      chk("ab_release", 32'(grant), 0);
      chk("ab_ptr", 32'(rr_ptr), 2);
      chk("ab_no_to", 32'(timeout_err), 0);

      // Owner strobe coincident with bus_send_finish
      do_reset();
      req_valid = 3'b001;
      step();
      send_byte(0, 8'h31, 1'b0, 1);
      step();
      send_byte(0, 8'h32, 1'b0, 2);
      chk("ov_fin_a", 32'(req_send_finish), 32'b001);
      req_byte[7:0] = 8'h40;
      req_byte_flag = 3'b001;
      exp_q.push_back(8'h40);
      step();
      req_byte_flag = '0;
      bus_send_finish = 1'b1;
      req_byte[7:0] = 8'h99;
      req_byte_flag = 3'b001;
      step();
      bus_send_finish = 1'b0;
      req_byte_flag = '0;
      chk("ov_fin", 32'(req_send_finish), 32'b001);
      chk("ov_pe", 32'(proto_err), 1);
      chk("ov_noflag", 32'(bus_data_flag), 0);
      chk("ov_state", 32'(state), 32'(GRANT));
      step();
      chk("ov_pe_width", 32'(proto_err), 0);
      send_byte(0, 8'h33, 1'b1, 2);
      req_valid = '0;
      step();
      chk("ov_pe_cnt", 32'(pe_cnt), 1);

      // Reset during WAIT_FIN
      req_valid = 3'b010;
      step();
      chk("rm_grant", 32'(grant), 32'b010);
      req_byte[15:8] = 8'h44;
      req_byte_flag = 3'b010;
      exp_q.push_back(8'h44);
      step();
      req_byte_flag = '0;
      step();
      chk("rm_state", 32'(state), 32'(WAIT_FIN));
      sys_rst = 1'b1;
      #1;
      chk("rm_grant0", 32'(grant), 0);
      chk("rm_busy0", 32'(busy), 0);
      chk("rm_data0", 32'(bus_data), 0);
      chk("rm_state0", 32'(state), 32'(IDLE));
      chk("rm_ptr0", 32'(rr_ptr), 0);
      req_valid = 3'b011;
      step();
      sys_rst = 1'b0;
      step();
      chk("rm_first", 32'(grant), 32'b001);
      chk("rm_fin0", 32'(req_send_finish), 0);
      req_valid = '0;
      step();
      step();

      chk("exp_q_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
